multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle opcode decoder of the 16-bit CPU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states using one shared memory port with a req/ready handshake.
- Generates per-state datapath controls, flags illegal opcodes, counts retired instructions, and halts on a memory-timeout fault.
- Sits between the instruction register/opcode field and the shared datapath (PC, IR, regfile, ALU, memory).

Parameters:
- OPCODE_W, 4, opcode field width; opcodes are matched in the low 4 bits, and any upper bits must be 0.
- TIMEOUT, 64, maximum wait cycles for mem_ready in FETCH or MEM; 0 disables the timeout.
- CNT_W, 16, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 0, when 1 an illegal opcode enters HALT; when 0 it is skipped as a NOP.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  start/continue execution
- opcode  in  OPCODE_W  opcode from the IR, valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  address select: 0=PC, 1=ALU result
- IRWrite  out  1  load the IR
- PCWrite  out  1  unconditional PC update (PC+2)
- Branch  out  1  conditional PC update on ALU zero
- RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite  out  1 each  datapath controls
- ALUOp  out  2  00=add, 01=sub/compare, 10=R-funct, 11=I-arith
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  FSM is in HALT
- fault  out  1  sticky memory-timeout flag
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- state  out  3  current state for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Outputs are Moore-decoded from the state register plus the latched instruction class, except PCWrite/IRWrite, which are qualified by mem_ready.
- Reset (async, reset_n=0):
  - state=IDLE; class register cleared; wait counter=0; instr_count=0; fault=0.
  - All outputs 0; state output reads 0.
- IDLE: all controls 0. run=1 → FETCH.
- FETCH:
  - mem_req=1, MemRead=1, IorD=0.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle → DECODE.
- DECODE:
  - Latch the class from opcode:
    - R = 0000, 0001, 0010
    - I = 1001, 1010, 1011
    - LW = 1100; SW = 1101; BEQ = 1111
    - ILL = all other values
  - ILL: illegal_op=1 for this cycle; next state = HALT if HALT_ON_ILLEGAL=1, else FETCH. The skip counts as retired.
  - Otherwise → EXEC. All controls are 0 in DECODE.
- EXEC:
  - R: ALUSrc=0, ALUOp=10 → WB.
  - I: ALUSrc=1, ALUOp=11 → WB.
  - LW/SW: ALUSrc=1, ALUOp=00 → MEM.
  - BEQ: ALUSrc=0, ALUOp=01, Branch=1 → retire.
- MEM:
  - mem_req=1, IorD=1, ALUSrc=1, ALUOp=00.
  - LW: MemRead=1; when mem_ready=1 → WB.
  - SW: MemWrite=1; when mem_ready=1 → retire.
- WB:
  - RegWrite=1.
  - R: RegDst=1, MemToReg=0.
  - I: RegDst=0, MemToReg=0.
  - LW: RegDst=0, MemToReg=1.
  - → retire.
- Retire:
  - instr_count += 1 on the retire transition.
  - Next state = FETCH if run=1, else IDLE.
  - run is sampled only at retire and in IDLE; dropping run mid-instruction completes the instruction first.
- Wait counter:
  - Clears on entry to FETCH or MEM; increments each cycle in FETCH/MEM while mem_ready=0.
  - With TIMEOUT≠0, when the counter reaches TIMEOUT with mem_ready=0: fault=1, → HALT, mem_req drops next cycle.
  - mem_ready=1 in the same cycle the counter reaches TIMEOUT wins: normal progress, no fault.
- HALT: all controls 0, halted=1. Exit only via reset; run is ignored.
- mem_ready outside FETCH/MEM is ignored.
- instr_count wraps from all-ones to 0 with no flag.
- Reset asserted mid-access drops mem_req asynchronously.

Test Plan:
- ADD (0001), mem_ready=1 every request, run=1 → states 1,2,3,5,1. WB has RegWrite=1, RegDst=1. instr_count=1 after 4 cycles.
- LW (1100) with mem_ready delayed 3 cycles in MEM → MEM held 4 cycles with mem_req=1, IorD=1, MemRead=1. Then WB with MemToReg=1, RegDst=0. instr_count +1.
- SW (1101) then BEQ (1111) → SW has MemWrite=1 in MEM, never enters WB. BEQ EXEC has Branch=1, ALUOp=01. Count +2.
- Opcode 0101 with HALT_ON_ILLEGAL=0 → illegal_op pulse in DECODE, back to FETCH, count +1. Rerun with HALT_ON_ILLEGAL=1 → halted=1 and held despite run=1.
- TIMEOUT=4, mem_ready stuck 0 in FETCH → fault=1, halted=1 after 4 wait cycles. Variant with mem_ready=1 on the 4th cycle → no fault.
- reset_n pulsed low mid-MEM, plus CNT_W=4 run of 17 instructions → all outputs 0 immediately, IDLE. instr_count wraps to 1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU: sequences FETCH/DECODE/EXEC/MEM/WB
// over one shared memory port, decodes datapath controls and tracks faults/retires.
module multicycle_control_fsm #(
  parameter int OPCODE_W        = 4,
  parameter int TIMEOUT         = 64,
  parameter int CNT_W           = 16,
  parameter int HALT_ON_ILLEGAL = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                Branch,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          ALUOp,
  output logic                illegal_op,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ILL = 3'd0,
    C_R   = 3'd1,
    C_I   = 3'd2,
    C_LW  = 3'd3,
    C_SW  = 3'd4,
    C_BEQ = 3'd5
  } cls_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RF  = 2'b10;
  localparam logic [1:0] ALU_IA  = 2'b11;

  // The wait counter never needs to exceed TIMEOUT-1 before the fault fires.
  localparam int              WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            r_state;
  state_t            w_next;
  cls_t              r_cls;
  cls_t              w_cls;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_count;
  logic              r_fault;
  logic              w_retire;
  logic              w_mem_state;
  logic              w_timeout;

  // Opcode classification; any set bit above the low nibble makes it illegal.
  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    w_cls = C_ILL;
    if ((opcode >> 4) == '0) begin
      unique case (opcode[3:0])
        4'b0000, 4'b0001, 4'b0010: w_cls = C_R;
        4'b1001, 4'b1010, 4'b1011: w_cls = C_I;
        4'b1100:                   w_cls = C_LW;
        4'b1101:                   w_cls = C_SW;
        4'b1111:                   w_cls = C_BEQ;
        default:                   w_cls = C_ILL;
      endcase
    end
  end

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout   = (TIMEOUT != 0) && w_mem_state && !mem_ready && (r_wait == WAIT_LAST);

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUOp      = ALU_ADD;
    illegal_op = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_HALT;
      end

      S_DECODE: begin
        if (w_cls == C_ILL) begin
          illegal_op = 1'b1;
          if (HALT_ON_ILLEGAL != 0) w_next   = S_HALT;
          else                      w_retire = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (r_cls)
          C_R: begin
            ALUOp  = ALU_RF;
            w_next = S_WB;
          end
          C_I: begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_IA;
            w_next = S_WB;
          end
          C_LW, C_SW: begin
            ALUSrc = 1'b1;
            w_next = S_MEM;
          end
          C_BEQ: begin
            ALUOp    = ALU_SUB;
            Branch   = 1'b1;
            w_retire = 1'b1;
          end
          default: w_retire = 1'b1;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        ALUSrc   = 1'b1;
        MemRead  = (r_cls == C_LW);
        MemWrite = (r_cls == C_SW);
        if (mem_ready) begin
          if (r_cls == C_LW) w_next   = S_WB;
          else               w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (r_cls == C_R);
        MemToReg = (r_cls == C_LW);
        w_retire = 1'b1;
      end

      S_HALT: w_next = S_HALT;

      default: w_next = S_IDLE;
    endcase

    // run is only consulted at instruction boundaries.
    if (w_retire) w_next = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cls   <= C_ILL;
      r_wait  <= '0;
      r_count <= '0;
      r_fault <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_cls;
      if (w_next != r_state)                r_wait <= '0;
      else if (w_mem_state && !mem_ready)   r_wait <= r_wait + 1'b1;
      if (w_retire)  r_count <= r_count + 1'b1;
      if (w_timeout) r_fault <= 1'b1;
    end
  end

  assign halted      = (r_state == S_HALT);
  assign fault       = r_fault;
  assign instr_count = r_count;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table on a
// TIMEOUT=4/CNT_W=4 instance, plus sequences for reset, wrap and halt-on-illegal.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, run, mem_ready;
  logic [3:0] opcode;

  logic       mem_req_a, iord_a, irw_a, pcw_a, br_a, rdst_a, asrc_a, m2r_a;
  logic       rw_a, mrd_a, mwr_a, ill_a, hlt_a, flt_a;
  logic [1:0] aop_a;
  logic [3:0] cnt_a;
  logic [2:0] st_a;

  logic        mem_req_b, iord_b, irw_b, pcw_b, br_b, rdst_b, asrc_b, m2r_b;
  logic        rw_b, mrd_b, mwr_b, ill_b, hlt_b, flt_b;
  logic [1:0]  aop_b;
  logic [15:0] cnt_b;
  logic [2:0]  st_b;

  multicycle_control_fsm #(.OPCODE_W(4), .TIMEOUT(4), .CNT_W(4), .HALT_ON_ILLEGAL(0)) dut_a (
    .clk(clk), .reset_n(rst_a), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req_a), .IorD(iord_a), .IRWrite(irw_a), .PCWrite(pcw_a), .Branch(br_a),
    .RegDst(rdst_a), .ALUSrc(asrc_a), .MemToReg(m2r_a), .RegWrite(rw_a), .MemRead(mrd_a),
    .MemWrite(mwr_a), .ALUOp(aop_a), .illegal_op(ill_a), .halted(hlt_a), .fault(flt_a),
    .instr_count(cnt_a), .state(st_a)
  );

  multicycle_control_fsm #(.OPCODE_W(4), .TIMEOUT(64), .CNT_W(16), .HALT_ON_ILLEGAL(1)) dut_b (
    .clk(clk), .reset_n(rst_b), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .IorD(iord_b), .IRWrite(irw_b), .PCWrite(pcw_b), .Branch(br_b),
    .RegDst(rdst_b), .ALUSrc(asrc_b), .MemToReg(m2r_b), .RegWrite(rw_b), .MemRead(mrd_b),
    .MemWrite(mwr_b), .ALUOp(aop_b), .illegal_op(ill_b), .halted(hlt_b), .fault(flt_b),
    .instr_count(cnt_b), .state(st_b)
  );

  // Control bundle, MSB first: req iord irw pcw br rdst asrc m2r rw mrd mwr aop[1:0] ill hlt flt
  logic [15:0] ctl_a, ctl_b;
  assign ctl_a = {mem_req_a, iord_a, irw_a, pcw_a, br_a, rdst_a, asrc_a, m2r_a,
                  rw_a, mrd_a, mwr_a, aop_a, ill_a, hlt_a, flt_a};
  assign ctl_b = {mem_req_b, iord_b, irw_b, pcw_b, br_b, rdst_b, asrc_b, m2r_b,
                  rw_b, mrd_b, mwr_b, aop_b, ill_b, hlt_b, flt_b};

  localparam logic [15:0] M_REQ  = 16'h8000, M_IORD = 16'h4000, M_IRW = 16'h2000;
  localparam logic [15:0] M_PCW  = 16'h1000, M_BR   = 16'h0800, M_RDST = 16'h0400;
  localparam logic [15:0] M_ASRC = 16'h0200, M_M2R  = 16'h0100, M_RW  = 16'h0080;
  localparam logic [15:0] M_MRD  = 16'h0040, M_MWR  = 16'h0020;
  localparam logic [15:0] A_SUB  = 16'h0008, A_RF   = 16'h0010, A_IA  = 16'h0018;
  localparam logic [15:0] M_ILL  = 16'h0004, M_HLT  = 16'h0002, M_FLT = 16'h0001;

  localparam logic [15:0] FETCH_W = M_REQ | M_MRD;
  localparam logic [15:0] FETCH_R = FETCH_W | M_IRW | M_PCW;
  localparam logic [15:0] EX_R    = A_RF;
  localparam logic [15:0] EX_I    = M_ASRC | A_IA;
  localparam logic [15:0] EX_M    = M_ASRC;
  localparam logic [15:0] EX_B    = M_BR | A_SUB;
  localparam logic [15:0] MEM_LW  = M_REQ | M_IORD | M_ASRC | M_MRD;
  localparam logic [15:0] MEM_SW  = M_REQ | M_IORD | M_ASRC | M_MWR;
  localparam logic [15:0] WB_R    = M_RW | M_RDST;
  localparam logic [15:0] WB_I    = M_RW;
  localparam logic [15:0] WB_LW   = M_RW | M_M2R;
  localparam logic [15:0] HLT_F   = M_HLT | M_FLT;

  typedef struct {
    logic        run;
    logic [3:0]  op;
    logic        rdy;
    logic [2:0]  st;
    logic [15:0] ctl;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] op, input logic rdy,
                     input logic [2:0] st, input logic [15:0] ctl, input logic [3:0] cnt);
    vec_t v;
    v.run = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; run = 1'b0; opcode = 4'h0; mem_ready = 1'b0;

    // One row per clock cycle: inputs, then state/controls/count seen before the edge.
    add(0, 4'h0, 0, 0, 0, 0);
    add(1, 4'h0, 0, 0, 0, 0);
    add(1, 4'h1, 1, 1, FETCH_R, 0);   // ADD
    add(1, 4'h1, 1, 2, 0, 0);
    add(1, 4'h1, 1, 3, EX_R, 0);
    add(1, 4'h1, 1, 5, WB_R, 0);
    add(1, 4'hC, 1, 1, FETCH_R, 1);   // LW, memory stalls 3 cycles
    add(1, 4'hC, 1, 2, 0, 1);
    add(1, 4'hC, 1, 3, EX_M, 1);
    add(1, 4'hC, 0, 4, MEM_LW, 1);
    add(1, 4'hC, 0, 4, MEM_LW, 1);
    add(1, 4'hC, 0, 4, MEM_LW, 1);
    add(1, 4'hC, 1, 4, MEM_LW, 1);    // ready on the TIMEOUT-th cycle wins
    add(1, 4'hC, 1, 5, WB_LW, 1);
    add(1, 4'hD, 1, 1, FETCH_R, 2);   // SW
    add(1, 4'hD, 1, 2, 0, 2);
    add(1, 4'hD, 1, 3, EX_M, 2);
    add(1, 4'hD, 1, 4, MEM_SW, 2);
    add(1, 4'hF, 1, 1, FETCH_R, 3);   // BEQ
    add(1, 4'hF, 1, 2, 0, 3);
    add(1, 4'hF, 1, 3, EX_B, 3);
    add(1, 4'hA, 1, 1, FETCH_R, 4);   // I-arith
    add(1, 4'hA, 1, 2, 0, 4);
    add(1, 4'hA, 1, 3, EX_I, 4);
    add(1, 4'hA, 1, 5, WB_I, 4);
    add(1, 4'h5, 1, 1, FETCH_R, 5);   // illegal, skipped
    add(1, 4'h5, 1, 2, M_ILL, 5);
    add(1, 4'h0, 0, 1, FETCH_W, 6);   // fetch stall, ready on 4th cycle
    add(1, 4'h0, 0, 1, FETCH_W, 6);
    add(1, 4'h0, 0, 1, FETCH_W, 6);
    add(1, 4'h0, 1, 1, FETCH_R, 6);
    add(1, 4'h0, 1, 2, 0, 6);
    add(0, 4'h0, 1, 3, EX_R, 6);      // run dropped mid-instruction
    add(0, 4'h0, 1, 5, WB_R, 6);
    add(0, 4'h0, 0, 0, 0, 7);
    add(0, 4'h0, 0, 0, 0, 7);
    add(1, 4'h0, 0, 0, 0, 7);
    add(1, 4'h0, 0, 1, FETCH_W, 7);   // fetch never completes
    add(1, 4'h0, 0, 1, FETCH_W, 7);
    add(1, 4'h0, 0, 1, FETCH_W, 7);
    add(1, 4'h0, 0, 1, FETCH_W, 7);
    add(1, 4'h0, 1, 6, HLT_F, 7);
    add(1, 4'h0, 1, 6, HLT_F, 7);

    repeat (2) @(negedge clk);
    #1;
    check("reset_state_a", st_a, 0);
    check("reset_ctl_a", ctl_a, 0);
    check("reset_cnt_a", cnt_a, 0);
    check("reset_ctl_b", ctl_b, 0);
    rst_a = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      run = vecs[i].run; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_state", i), st_a, vecs[i].st);
      check($sformatf("vec%0d_ctl", i), ctl_a, vecs[i].ctl);
      check($sformatf("vec%0d_cnt", i), cnt_a, vecs[i].cnt);
    end

    // Reset out of HALT clears the sticky fault.
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("halt_reset_state", st_a, 0);
    check("halt_reset_fault", flt_a, 0);

    // Reset asserted between edges while an LW waits in MEM.
    @(negedge clk);
    rst_a = 1'b1; run = 1'b1; opcode = 4'hC; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("mid_mem_state", st_a, 4);
    check("mid_mem_req", mem_req_a, 1);
    #2;
    rst_a = 1'b0;
    #1;
    check("async_reset_req", mem_req_a, 0);
    check("async_reset_state", st_a, 0);
    check("async_reset_ctl", ctl_a, 0);

    // 17 back-to-back BEQs through a 4-bit counter.
    @(negedge clk);
    rst_a = 1'b1; run = 1'b1; opcode = 4'hF; mem_ready = 1'b1;
    repeat (48) @(negedge clk);
    #1;
    check("wrap_cnt15", cnt_a, 15);
    check("wrap_state_exec", st_a, 3);
    @(negedge clk);
    #1;
    check("wrap_cnt0", cnt_a, 0);
    check("wrap_state_fetch", st_a, 1);
    repeat (3) @(negedge clk);
    #1;
    check("wrap_cnt1", cnt_a, 1);

    // Halt-on-illegal instance.
    @(negedge clk);
    rst_b = 1'b1; run = 1'b1; opcode = 4'h5; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("b_fetch_state", st_b, 1);
    check("b_fetch_ctl", ctl_b, FETCH_R);
    @(negedge clk);
    #1;
    check("b_decode_state", st_b, 2);
    check("b_illegal_ctl", ctl_b, M_ILL);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("b_halt%0d_state", k), st_b, 6);
      check($sformatf("b_halt%0d_ctl", k), ctl_b, M_HLT);
    end
    check("b_halt_cnt", cnt_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
